// File: rtl/hcsr04_pkg.sv
// Shared types and elaboration-time helpers for the HC-SR04 multi-channel ranger.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_e;

  // Clock cycles per microsecond.
  function automatic int us_div(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // The microsecond tick is only exact for whole-MHz clocks.
  function automatic bit clk_ok(input int clk_hz);
    return (clk_hz >= 1_000_000) && ((clk_hz % 1_000_000) == 0);
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Result field must hold TIMEOUT_US without wrapping.
  function automatic bit w_fits(input int w, input int timeout_us);
    return (longint'(1) << w) > longint'(timeout_us);
  endfunction

  // The shared phase counter also times TRIG and GAP, which may exceed W bits.
  function automatic int cnt_width(input int w, input int trig_us, input int gap_us);
    int m;
    m = w;
    if ($clog2(trig_us + 1) > m) m = $clog2(trig_us + 1);
    if ($clog2(gap_us + 1) > m)  m = $clog2(gap_us + 1);
    return m;
  endfunction

endpackage

// File: rtl/hcsr04_multi_ranger_us_tick.sv
// Microsecond prescaler: counts 0..DIV-1, ticks on DIV-1, restarts on i_clr.
module ranger_us_tick #(
  parameter int DIV = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  // Wrap at DIV-1; a clear always wins so the next phase starts on a full period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   r_cnt <= '0;
    else if (i_clr || r_cnt == LAST) r_cnt <= '0;
    else                            r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/hcsr04_multi_ranger.sv
// Round-robin HC-SR04 controller: one sensor triggered at a time, echo width
// measured in microseconds with timeout/saturation, per-channel result registers.
module hcsr04_multi_ranger
  import hcsr04_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 38000,
  parameter int GAP_US     = 60000,
  parameter int W          = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        enable,
  input  logic                        mode_cont,
  input  logic                        start,
  input  logic [NUM_CH-1:0]           hcecho_export,
  output logic [NUM_CH-1:0]           hctrig_export,
  output logic [NUM_CH*W-1:0]         dist_us,
  output logic [NUM_CH-1:0]           timeout_flags,
  output logic                        sample_valid,
  output logic [ch_width(NUM_CH)-1:0] sample_ch,
  output logic                        busy
);

  localparam int              DIV     = us_div(CLK_HZ);
  localparam int              CH_W    = ch_width(NUM_CH);
  localparam int              CW      = cnt_width(W, TRIG_US, GAP_US);
  localparam logic [CW-1:0]   C_TRIG  = CW'(TRIG_US);
  localparam logic [CW-1:0]   C_TO    = CW'(TIMEOUT_US);
  localparam logic [CW-1:0]   C_GAP   = CW'(GAP_US);
  localparam logic [W-1:0]    TO_W    = W'(TIMEOUT_US);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("hcsr04_multi_ranger: NUM_CH must be 1..8");
  end
  if (!clk_ok(CLK_HZ)) begin : g_bad_clk
    $error("hcsr04_multi_ranger: CLK_HZ must be a multiple of 1 MHz");
  end
  if (!w_fits(W, TIMEOUT_US)) begin : g_bad_w
    $error("hcsr04_multi_ranger: W too narrow for TIMEOUT_US");
  end

  state_e                  r_state, w_state_nxt;
  logic [CH_W-1:0]         r_ch, w_ch_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_inc;
  logic [NUM_CH-1:0]       r_sync1, r_sync2;
  logic                    r_echo_prev;
  logic                    w_echo, w_rise, w_fall;
  logic                    w_tick, w_clr, w_meas;
  logic                    w_rec, w_rec_to;
  logic [W-1:0]            w_rec_val;
  logic [NUM_CH-1:0]       w_trig_nxt;
  logic [NUM_CH-1:0]       r_trig;
  logic                    r_busy;
  logic [NUM_CH-1:0][W-1:0] r_dist;
  logic [NUM_CH-1:0]       r_flags;
  logic                    r_sv;
  logic [CH_W-1:0]         r_sch;

  // Every state change restarts both the prescaler and the microsecond count.
  assign w_clr  = (w_state_nxt != r_state);
  assign w_meas = (r_state == WAIT_RISE) || (r_state == MEASURE);

  ranger_us_tick #(
    .DIV (DIV)
  ) u_tick (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // Two-flop synchronisers on all raw echo pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= hcecho_export;
      r_sync2 <= r_sync1;
    end
  end

  // Only the active channel is edge-detected. The previous-value flop reloads
  // during TRIG, so a pin already high at WAIT_RISE entry never counts as a rise.
  assign w_echo = r_sync2[r_ch];
  assign w_rise = w_echo & ~r_echo_prev;
  assign w_fall = ~w_echo & r_echo_prev;

  // Previous-cycle echo for edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_echo_prev <= 1'b0;
    else                r_echo_prev <= w_echo;
  end

  // Count including this cycle's tick; saturates at TIMEOUT_US while measuring.
  always_comb begin
    w_cnt_inc = r_cnt;
    if (w_tick && !(w_meas && r_cnt >= C_TO)) w_cnt_inc = r_cnt + 1'b1;
  end

  // Phase counter register; held at zero while idle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)               r_cnt <= '0;
    else if (w_clr || r_state == IDLE) r_cnt <= '0;
    else                              r_cnt <= w_cnt_inc;
  end

  // State and channel register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  // Next-state, channel sequencing and result-record decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_rec       = 1'b0;
    w_rec_to    = 1'b0;
    w_rec_val   = w_cnt_inc[W-1:0];
    case (r_state)
      IDLE: begin
        if (enable && (mode_cont || start)) begin
          w_state_nxt = TRIG;
          w_ch_nxt    = '0;
        end
      end
      TRIG: begin
        if (w_cnt_inc == C_TRIG) w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        // A rise in the final microsecond still wins over the timeout.
        if (w_rise) begin
          w_state_nxt = MEASURE;
        end else if (w_cnt_inc >= C_TO) begin
          w_rec       = 1'b1;
          w_rec_to    = 1'b1;
          w_rec_val   = TO_W;
          w_state_nxt = GAP;
        end
      end
      MEASURE: begin
        if (w_cnt_inc >= C_TO) begin
          w_rec       = 1'b1;
          w_rec_to    = 1'b1;
          w_rec_val   = TO_W;
          w_state_nxt = GAP;
        end else if (w_fall) begin
          w_rec       = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_cnt_inc == C_GAP) begin
          if (r_ch != LAST_CH) begin
            w_ch_nxt    = r_ch + 1'b1;
            w_state_nxt = TRIG;
          end else begin
            // End of pass: only a still-enabled continuous run loops to ch0.
            w_ch_nxt    = '0;
            w_state_nxt = (enable && mode_cont) ? TRIG : IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ch_nxt    = '0;
      end
    endcase
  end

  // Trigger pattern for the next cycle: one-hot on the channel entering/in TRIG.
  always_comb begin
    w_trig_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_trig_nxt[i] = (w_state_nxt == TRIG) && (w_ch_nxt == CH_W'(i));
  end

  // Registered trigger and busy so both pins are glitch-free; reset clears them at once.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_trig <= '0;
      r_busy <= 1'b0;
    end else begin
      r_trig <= w_trig_nxt;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  // Result registers and the one-cycle sample strobe; other channels untouched.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_dist  <= '0;
      r_flags <= '0;
      r_sv    <= 1'b0;
      r_sch   <= '0;
    end else begin
      r_sv <= w_rec;
      if (w_rec) begin
        r_sch         <= r_ch;
        r_dist[r_ch]  <= w_rec_val;
        r_flags[r_ch] <= w_rec_to;
      end
    end
  end

  assign hctrig_export = r_trig;
  assign busy          = r_busy;
  assign dist_us       = r_dist;
  assign timeout_flags = r_flags;
  assign sample_valid  = r_sv;
  assign sample_ch     = r_sch;

endmodule

// File: tb/tb_hcsr04_multi_ranger.sv
// Bench for hcsr04_multi_ranger: table of per-channel measurements, randomized
// continuous run against an arithmetic reference model, and reset corner cases.
module tb_hcsr04_multi_ranger;

  localparam int NUM_CH     = 2;
  localparam int CLK_HZ     = 10_000_000;
  localparam int DIV        = 10;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 200;
  localparam int GAP_US     = 20;
  localparam int W          = 16;

  logic                   clk_clk       = 1'b0;
  logic                   reset_reset_n = 1'b0;
  logic                   enable        = 1'b0;
  logic                   mode_cont     = 1'b0;
  logic                   start         = 1'b0;
  logic [NUM_CH-1:0]      hcecho_export = '0;
  logic [NUM_CH-1:0]      hctrig_export;
  logic [NUM_CH*W-1:0]    dist_us;
  logic [NUM_CH-1:0]      timeout_flags;
  logic                   sample_valid;
  logic [0:0]             sample_ch;
  logic                   busy;

  int n_chk  = 0;
  int n_fail = 0;
  int m_dist [NUM_CH];
  bit m_flag [NUM_CH];

  typedef struct {
    int ch;
    bit kick;   // pulse start before waiting for the trigger
    bit pre;    // echo already high before the trigger
    bit rise;   // echo rises after the trigger
    int dly;    // cycles after trigger end before the rise
    int wid;    // raw echo high width in cycles
    bit gap;    // check settle time since the previous sample
    bit poke;   // pulse start while busy (must be ignored)
    bit drop;   // drop enable during this measurement
    bit last;   // pass ends here: check return to idle
    int exp_d;
    bit exp_f;
  } vec_t;

  hcsr04_multi_ranger #(
    .NUM_CH     (NUM_CH),
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .GAP_US     (GAP_US),
    .W          (W)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .mode_cont     (mode_cont),
    .start         (start),
    .hcecho_export (hcecho_export),
    .hctrig_export (hctrig_export),
    .dist_us       (dist_us),
    .timeout_flags (timeout_flags),
    .sample_valid  (sample_valid),
    .sample_ch     (sample_ch),
    .busy          (busy)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick1();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] oh(input int c);
    logic [NUM_CH-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // Echo duration in whole microseconds is the raw high time divided by the
  // cycles per microsecond; no rise, or a result at/over the limit, is a timeout.
  function automatic void model(input vec_t v, output int d, output bit f);
    int us;
    us = v.wid / DIV;
    if (v.pre || !v.rise || us >= TIMEOUT_US) begin
      d = TIMEOUT_US;
      f = 1'b1;
    end else begin
      d = us;
      f = 1'b0;
    end
  endfunction

  task automatic run_ch(input vec_t v);
    int n, k, exp_k;
    logic [NUM_CH*W-1:0] e_all;
    logic [NUM_CH-1:0]   e_flags;
    if (v.pre) hcecho_export[v.ch] = 1'b1;
    if (v.kick) begin
      start = 1'b1;
      tick1();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
    end
    n = 0;
    while (hctrig_export !== oh(v.ch) && n < 5000) begin
      tick1();
      n++;
    end
    chk("trig_onehot", hctrig_export, oh(v.ch));
    // The strobe cycle was already consumed, so 199 cycles remain of the 200-cycle gap.
    if (v.gap) chk("gap_cycles", n, GAP_US * DIV - 1);
    n = 1;
    while (n < 1000) begin
      tick1();
      if (hctrig_export[v.ch]) n++;
      else break;
    end
    chk("trig_width", n, TRIG_US * DIV);
    k = 0;
    if (v.rise) begin
      repeat (v.dly) tick1();
      hcecho_export[v.ch] = 1'b1;
      while (!sample_valid && k < 3000) begin
        tick1();
        k++;
        if (k == v.wid) hcecho_export[v.ch] = 1'b0;
        if (v.drop && k == 10) enable = 1'b0;
      end
      exp_k = ((v.wid < TIMEOUT_US * DIV) ? v.wid : TIMEOUT_US * DIV) + 3;
    end else begin
      while (!sample_valid && k < 3000) begin
        tick1();
        k++;
        start = v.poke && (k == 5);
      end
      exp_k = TIMEOUT_US * DIV;
    end
    start = 1'b0;
    hcecho_export[v.ch] = 1'b0;
    m_dist[v.ch] = v.exp_d;
    m_flag[v.ch] = v.exp_f;
    chk("sample_latency", k, exp_k);
    chk("sample_valid", sample_valid, 1);
    chk("sample_ch", sample_ch, v.ch);
    chk("dist", dist_us[v.ch*W +: W], v.exp_d);
    chk("timeout_flag", timeout_flags[v.ch], v.exp_f);
    for (int i = 0; i < NUM_CH; i++) begin
      e_all[i*W +: W] = W'(m_dist[i]);
      e_flags[i]      = m_flag[i];
    end
    chk("dist_all", dist_us, e_all);
    chk("flags_all", timeout_flags, e_flags);
    tick1();
    chk("strobe_len", sample_valid, 0);
  endtask

  task automatic chk_idle(input string nm);
    repeat (GAP_US * DIV + 5) tick1();
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_trig"}, hctrig_export, 0);
  endtask

  initial begin
    vec_t tbl [4];
    vec_t v;
    int   d;
    bit   f;

    for (int i = 0; i < NUM_CH; i++) begin
      m_dist[i] = 0;
      m_flag[i] = 1'b0;
    end

    tbl[0] = '{ch:0, kick:1, pre:0, rise:1, dly:5, wid:570, gap:0, poke:0, drop:0, last:0,
               exp_d:57, exp_f:0};
    tbl[1] = '{ch:1, kick:0, pre:0, rise:0, dly:0, wid:0, gap:1, poke:1, drop:0, last:1,
               exp_d:200, exp_f:1};
    tbl[2] = '{ch:0, kick:1, pre:1, rise:0, dly:0, wid:0, gap:0, poke:0, drop:0, last:0,
               exp_d:200, exp_f:1};
    tbl[3] = '{ch:1, kick:0, pre:0, rise:1, dly:3, wid:3000, gap:1, poke:0, drop:0, last:1,
               exp_d:200, exp_f:1};

    // Reset state
    repeat (3) tick1();
    chk("rst_trig", hctrig_export, 0);
    chk("rst_dist", dist_us, 0);
    chk("rst_flags", timeout_flags, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ch", sample_ch, 0);
    chk("rst_busy", busy, 0);
    reset_reset_n = 1'b1;
    tick1();
    chk("idle_busy", busy, 0);

    // Single passes from the table
    enable    = 1'b1;
    mode_cont = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_ch(tbl[i]);
      if (tbl[i].last) chk_idle("pass_end");
    end

    // Continuous round-robin with random echoes
    mode_cont = 1'b1;
    for (int r = 0; r < 6; r++) begin
      v = '{ch:r % 2, kick:0, pre:0, rise:($urandom_range(0, 4) != 0),
            dly:$urandom_range(0, 60), wid:$urandom_range(10, 2400),
            gap:(r != 0), poke:0, drop:0, last:0, exp_d:0, exp_f:0};
      model(v, d, f);
      v.exp_d = d;
      v.exp_f = f;
      run_ch(v);
    end

    // Enable dropped during ch0 MEASURE: ch0 and ch1 still complete, then idle
    v = '{ch:0, kick:0, pre:0, rise:1, dly:4, wid:300, gap:1, poke:0, drop:1, last:0,
          exp_d:30, exp_f:0};
    run_ch(v);
    v = '{ch:1, kick:0, pre:0, rise:1, dly:2, wid:1234, gap:1, poke:0, drop:0, last:0,
          exp_d:123, exp_f:0};
    run_ch(v);
    chk_idle("drop_en");

    // Reset asserted in the middle of TRIG
    mode_cont = 1'b0;
    enable    = 1'b1;
    start     = 1'b1;
    tick1();
    start = 1'b0;
    chk("rtrig_on", hctrig_export, 2'b01);
    repeat (20) tick1();
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("rtrig_async_drop", hctrig_export, 0);
    chk("rtrig_busy", busy, 0);
    tick1();
    reset_reset_n = 1'b1;
    tick1();
    chk("rtrig_dist", dist_us, 0);
    chk("rtrig_flags", timeout_flags, 0);
    chk("rtrig_valid", sample_valid, 0);
    chk("rtrig_ch", sample_ch, 0);
    chk("rtrig_trig", hctrig_export, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
